// File: rtl/fpu_arb_pkg.sv
// Shared types for the FPU sharing arbiter and the bus arbiter that reuses its picker.
package fpu_arb_pkg;

    localparam int unsigned FPU_OP_W   = 4;
    localparam int unsigned FPU_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    typedef logic [FPU_OP_W-1:0] fpu_op_t;

    typedef struct packed {
        fpu_op_t               op;
        logic [FPU_DATA_W-1:0] a;
        logic [FPU_DATA_W-1:0] b;
    } fpu_req_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or above base, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        logic [IW-1:0] pos;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = IW'((32'(base) + k) % N);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Round-robin sharing of one FPU between NUM_REQ requesters, one operation in flight,
// with a WAIT-state watchdog that flushes the FPU and answers with an error.
module fpu_share_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned OP_W        = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*OP_W-1:0]     req_op,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err,
    output logic                        fpu_valid,
    input  logic                        fpu_ready,
    output logic [OP_W-1:0]             fpu_op,
    output logic [DATA_W-1:0]           fpu_a,
    output logic [DATA_W-1:0]           fpu_b,
    input  logic                        fpu_rsp_valid,
    input  logic [DATA_W-1:0]           fpu_rsp_data,
    output logic                        fpu_flush,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int unsigned IW       = idx_w(NUM_REQ);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [15:0]       timer_q, timer_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               tmo_last;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req  (req_valid),
        .base (rr_ptr_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign tmo_last = (timer_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            data_q   <= data_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        data_d   = data_q;
        err_d    = err_q;
        timer_d  = timer_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    op_d    = req_op[32'(pick_idx) * OP_W +: OP_W];
                    a_d     = req_a[32'(pick_idx) * DATA_W +: DATA_W];
                    b_d     = req_b[32'(pick_idx) * DATA_W +: DATA_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (fpu_ready) begin
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + 16'd1;
                // A result arriving in the timeout cycle beats the watchdog.
                if (fpu_rsp_valid) begin
                    data_d  = fpu_rsp_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmo_last) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rr_ptr_d = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        fpu_valid = 1'b0;
        fpu_flush = 1'b0;
        case (state_q)
            IDLE:  req_ready = pick_gnt;
            ISSUE: fpu_valid = 1'b1;
            WAIT:  fpu_flush = tmo_last && !fpu_rsp_valid;
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                rsp_data           = data_q;
                rsp_err            = err_q;
            end
            default: ;
        endcase
    end

    assign fpu_op   = op_q;
    assign fpu_a    = a_q;
    assign fpu_b    = b_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model of the arbitration rules.
module tb_fpu_share_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned OW  = 4;
    localparam int unsigned TMO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, rsp_valid;
    logic [N*OW-1:0] req_op;
    logic [N*DW-1:0] req_a, req_b;
    logic [DW-1:0]   rsp_data, fpu_a, fpu_b, fpu_rsp_data;
    logic            rsp_err, fpu_valid, fpu_ready, fpu_rsp_valid, fpu_flush, busy;
    logic [OW-1:0]   fpu_op;
    logic [1:0]      grant_id;

    fpu_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fpu_valid(fpu_valid), .fpu_ready(fpu_ready),
        .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_rsp_valid(fpu_rsp_valid), .fpu_rsp_data(fpu_rsp_data),
        .fpu_flush(fpu_flush), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: one operation record plus the round-robin pointer.
    int unsigned m_ptr, m_gid, m_wait;
    bit          m_busy, m_issued, m_done, m_err;
    logic [OW-1:0] m_op;
    logic [DW-1:0] m_a, m_b, m_res;

    // Snapshot of outputs at the last compare.
    logic [N-1:0]  s_ready, s_rsp;
    logic          s_fv, s_flush, s_err, s_busy;
    logic [DW-1:0] s_data;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Winner = valid requester with the smallest rotational distance from ptr.
    function automatic int pick(input logic [N-1:0] v, input int unsigned ptr);
        int          best = -1;
        int unsigned bd   = N;
        for (int i = 0; i < N; i++) begin
            if (v[i] && ((i + N - ptr) % N) < bd) begin
                bd   = (i + N - ptr) % N;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_gid = 0; m_wait = 0;
        m_busy = 0; m_issued = 0; m_done = 0; m_err = 0;
        m_op = '0; m_a = '0; m_b = '0; m_res = '0;
    endtask

    task automatic model_step();
        int w;
        if (rst) begin
            model_reset();
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
            m_ptr  = (m_gid + 1) % N;
        end else if (!m_busy) begin
            w = pick(req_valid, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_issued = 0; m_gid = w;
                m_op = req_op[w*OW +: OW];
                m_a  = req_a[w*DW +: DW];
                m_b  = req_b[w*DW +: DW];
            end
        end else if (!m_issued) begin
            if (fpu_ready) begin m_issued = 1; m_wait = 0; end
        end else if (fpu_rsp_valid) begin
            m_res = fpu_rsp_data; m_err = 0; m_done = 1;
        end else if (m_wait + 1 == TMO) begin
            m_res = '0; m_err = 1; m_done = 1;
        end else begin
            m_wait++;
        end
    endtask

    task automatic compare();
        logic [N-1:0] e_ready, e_rsp;
        logic         e_flush;
        int           w;
        e_ready = '0;
        e_rsp   = '0;
        w = pick(req_valid, m_ptr);
        if (!m_busy && w >= 0) e_ready[w] = 1'b1;
        if (m_done) e_rsp[m_gid] = 1'b1;
        e_flush = m_busy && m_issued && !m_done && !fpu_rsp_valid && (m_wait + 1 == TMO);
        expect_eq("req_ready", 64'(req_ready), 64'(e_ready));
        expect_eq("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        if (m_done) begin
            expect_eq("rsp_data", 64'(rsp_data), 64'(m_res));
            expect_eq("rsp_err", 64'(rsp_err), 64'(m_err));
        end
        expect_eq("fpu_valid", 64'(fpu_valid), 64'(m_busy && !m_issued));
        if (m_busy && !m_issued) begin
            expect_eq("fpu_op", 64'(fpu_op), 64'(m_op));
            expect_eq("fpu_a", 64'(fpu_a), 64'(m_a));
            expect_eq("fpu_b", 64'(fpu_b), 64'(m_b));
        end
        expect_eq("fpu_flush", 64'(fpu_flush), 64'(e_flush));
        expect_eq("busy", 64'(busy), 64'(m_busy));
        expect_eq("grant_id", 64'(grant_id), 64'(m_gid));
        s_ready = req_ready; s_rsp = rsp_valid; s_fv = fpu_valid; s_flush = fpu_flush;
        s_err = rsp_err; s_data = rsp_data; s_busy = busy;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; fpu_ready = 1'b0; fpu_rsp_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        expect_eq(tag, 64'({req_ready, rsp_valid, rsp_err, fpu_valid, fpu_flush, busy, grant_id, fpu_op}), 64'd0);
        expect_eq({tag, "_data"}, 64'({rsp_data, fpu_a}), 64'd0);
        expect_eq({tag, "_b"}, 64'(fpu_b), 64'd0);
    endtask

    task automatic load_req(input int i);
        req_op[i*OW +: OW] = OW'($urandom);
        req_a[i*DW +: DW]  = $urandom;
        req_b[i*DW +: DW]  = $urandom;
    endtask

    task automatic rand_drive();
        for (int i = 0; i < N; i++) begin
            if (req_valid[i]) begin
                if (s_ready[i] || $urandom_range(99) < 3) req_valid[i] = 1'b0;
            end else if ($urandom_range(99) < 35) begin
                req_valid[i] = 1'b1;
                load_req(i);
            end
        end
        fpu_ready     = ($urandom_range(99) < 60);
        fpu_rsp_valid = ($urandom_range(99) < 18);
        fpu_rsp_data  = $urandom;
        rst           = ($urandom_range(999) < 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int acc_id[$];
        int acc_cyc[$];
        int k, cnt, bcnt, flush_k, rsp_k, n_flush;
        logic rsp_e;
        logic [DW-1:0] rsp_d;

        rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        fpu_ready = 1'b0; fpu_rsp_valid = 1'b0; fpu_rsp_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset_state");

        // Single operation from requester 2.
        req_valid = 4'b0100; req_op[8 +: 4] = 4'h3;
        req_a[64 +: 32] = 32'h3F800000; req_b[64 +: 32] = 32'h40000000; fpu_ready = 1'b1;
        cycle();
        req_valid = '0;
        cycle();
        fpu_rsp_valid = 1'b1; fpu_rsp_data = 32'h40400000;
        cycle();
        fpu_rsp_valid = 1'b0;
        expect_eq("single_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
        expect_eq("single_rsp_data", 64'(rsp_data), 64'(32'h40400000));
        expect_eq("single_rsp_err", 64'(rsp_err), 64'd0);
        expect_eq("single_grant_id", 64'(grant_id), 64'd2);
        cycle();

        // Contention: all four held, FPU answers immediately.
        do_reset();
        for (int i = 0; i < N; i++) load_req(i);
        req_valid = 4'hF; fpu_ready = 1'b1; fpu_rsp_valid = 1'b1; fpu_rsp_data = $urandom;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (s_ready != '0) begin
                for (int i = 0; i < N; i++) if (s_ready[i]) acc_id.push_back(i);
                acc_cyc.push_back(c);
            end
        end
        expect_eq("rr_accepts", 64'(acc_id.size()), 64'd5);
        for (int j = 0; j < acc_id.size() && j < 5; j++) begin
            expect_eq("rr_order", 64'(acc_id[j]), 64'(j % N));
            if (j > 0) expect_eq("rr_spacing", 64'(acc_cyc[j] - acc_cyc[j-1]), 64'd4);
        end
        fpu_rsp_valid = 1'b0;

        // Backpressure: fpu_ready low for five ISSUE cycles.
        do_reset();
        load_req(0);
        req_valid = 4'b0001; fpu_ready = 1'b0;
        cycle();
        req_valid = '0;
        cnt = 0; bcnt = 0;
        for (int c = 0; c < 5; c++) begin
            load_req(0);
            cycle();
            cnt += int'(s_fv); bcnt += int'(s_busy);
        end
        fpu_ready = 1'b1;
        cycle();
        cnt += int'(s_fv); bcnt += int'(s_busy);
        expect_eq("bp_fv_cycles", 64'(cnt), 64'd6);
        expect_eq("bp_busy_cycles", 64'(bcnt), 64'd6);
        expect_eq("bp_fv_after", 64'(fpu_valid), 64'd0);
        fpu_rsp_valid = 1'b1; fpu_rsp_data = $urandom;
        cycle();
        fpu_rsp_valid = 1'b0;
        cycle();

        // Timeout, then a stray FPU result in IDLE.
        do_reset();
        load_req(1);
        req_valid = 4'b0010; fpu_ready = 1'b1;
        cycle();
        req_valid = '0;
        flush_k = -1; rsp_k = -1; n_flush = 0; rsp_e = 1'b0; rsp_d = '1;
        for (k = 1; k <= 12; k++) begin
            cycle();
            if (s_flush) begin flush_k = k; n_flush++; end
            if (s_rsp != '0) begin rsp_k = k; rsp_e = s_err; rsp_d = s_data; end
        end
        expect_eq("tmo_flush_count", 64'(n_flush), 64'd1);
        expect_eq("tmo_flush_cycle", 64'(flush_k), 64'd9);
        expect_eq("tmo_rsp_cycle", 64'(rsp_k), 64'd10);
        expect_eq("tmo_rsp_err", 64'(rsp_e), 64'd1);
        expect_eq("tmo_rsp_data", 64'(rsp_d), 64'd0);
        fpu_rsp_valid = 1'b1; fpu_rsp_data = 32'hDEADBEEF;
        cycle();
        fpu_rsp_valid = 1'b0;
        expect_eq("stray_rsp_valid", 64'(rsp_valid), 64'd0);
        cycle();

        // Collision: result arrives in the timeout cycle.
        do_reset();
        load_req(3);
        req_valid = 4'b1000; fpu_ready = 1'b1;
        cycle();
        req_valid = '0;
        n_flush = 0; rsp_k = -1; rsp_e = 1'b1; rsp_d = '0;
        for (k = 1; k <= 11; k++) begin
            fpu_rsp_valid = (k == 9);
            fpu_rsp_data  = 32'h1234_5678;
            cycle();
            if (s_flush) n_flush++;
            if (s_rsp != '0) begin rsp_k = k; rsp_e = s_err; rsp_d = s_data; end
        end
        fpu_rsp_valid = 1'b0;
        expect_eq("coll_flush_count", 64'(n_flush), 64'd0);
        expect_eq("coll_rsp_cycle", 64'(rsp_k), 64'd10);
        expect_eq("coll_rsp_err", 64'(rsp_e), 64'd0);
        expect_eq("coll_rsp_data", 64'(rsp_d), 64'(32'h1234_5678));

        // Reset mid-WAIT with the pointer at 3.
        do_reset();
        load_req(2);
        req_valid = 4'b0100; fpu_ready = 1'b1;
        cycle();
        req_valid = '0;
        cycle();
        fpu_rsp_valid = 1'b1;
        cycle();
        fpu_rsp_valid = 1'b0;
        cycle();
        load_req(0); load_req(3);
        req_valid = 4'b1001;
        cycle();
        expect_eq("pre_rst_grant", 64'(grant_id), 64'd3);
        req_valid = 4'b0001;
        cycle();
        cycle();
        rst = 1'b1; req_valid = '0;
        cycle();
        rst = 1'b0;
        check_all_zero("mid_wait_reset");
        req_valid = 4'b1001;
        #1;
        expect_eq("post_rst_ready", 64'(req_ready), 64'(4'b0001));
        cycle();
        expect_eq("post_rst_grant", 64'(grant_id), 64'd0);
        req_valid = '0;

        // Random traffic.
        do_reset();
        s_ready = '0;
        for (int c = 0; c < 1500; c++) begin
            rand_drive();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
